// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM states and address constants for the fetch path
package cpu_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, UPDATE, HALT} state_t;
  localparam int INSTR_BYTES = 4;
  localparam int ADDR_ALIGN_MASK = ~3;
endpackage

// File: rtl/npc_sel.sv
// npc_sel: jump > branch > sequential next-address select, word-aligned
module npc_sel
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jmp_i,
  input  logic [ADDR_W-1:0] jmp_target_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_target_i,
  output logic [ADDR_W-1:0] nxt_o
);
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(ADDR_ALIGN_MASK);
  assign nxt_o = (jmp_i ? jmp_target_i : br_taken_i ? br_target_i : pc_i + ADDR_W'(INSTR_BYTES)) & MASK;
endmodule

// File: rtl/ifetch_npc.sv
// ifetch_npc: instruction fetch over req/ack and next-PC control
module ifetch_npc
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic [ADDR_W-1:0] npc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic [31:0]       ir,
  output logic              ir_valid,
  input  logic              core_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  output logic [31:0]       instr_cnt,
  output logic              fetch_err
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [31:0] ir_q, ir_d, cnt_q, cnt_d;
  logic ir_valid_q, ir_valid_d, err_q, err_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] nxt_q, nxt_d, sel;
  npc_sel #(.ADDR_W(ADDR_W)) u_sel (
    .pc_i(pc_cur), .jmp_i(jmp), .jmp_target_i(jmp_target),
    .br_taken_i(br_taken), .br_target_i(br_target), .nxt_o(sel)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      wait_q     <= '0;
      nxt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
      nxt_q      <= nxt_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    wait_d     = wait_q;
    nxt_d      = nxt_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          ir_d       = imem_rdata;
          ir_valid_d = 1'b1;
          wait_d     = '0;
          state_d    = ISSUE;
        end else if (wait_q == LAST) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else wait_d = wait_q + 1'b1;
      end
      ISSUE: begin
        if (core_ready) begin
          nxt_d      = sel;
          ir_valid_d = 1'b0;
          cnt_d      = cnt_q + 32'd1;
          state_d    = UPDATE;
        end
      end
      UPDATE: state_d = FETCH;
      default: state_d = state_q;
    endcase
  end
  // PC register reloads every edge, so only UPDATE presents a new address
  assign npc       = (state_q == UPDATE) ? nxt_q : pc_cur;
  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_cur;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign instr_cnt = cnt_q;
  assign fetch_err = err_q;
endmodule
